// File: rtl/ps2_sb_ctrl.sv
// ============================================================================
// Module  : ps2_sb_ctrl
// Brief   : PS/2 keyboard receiver with system-bus slave registers and IRQ.
//           Optional sticky overrun flag at 0x08 under `define PS2_OVERRUN_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module ps2_sb_ctrl #(
   parameter int TIMEOUT_CYCLES = 2000
) (
   input  logic        clk_i,
   input  logic        resetn_i,
   input  logic        req_i,
   input  logic        write_enable_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] write_data_i,
   output logic [31:0] read_data_o,
   output logic        ready_o,
   input  logic        kclk_i,
   input  logic        kdata_i,
   output logic        interrupt_request_o,
   input  logic        interrupt_return_i
);

   localparam int c_to_w = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } state_t;

   state_t              r_state;
   logic [2:0]          r_bit_cnt;
   logic [7:0]          r_shift;
   logic                r_parity;
   logic [c_to_w-1:0]   r_to_cnt;
   logic [7:0]          r_scan_code;
   logic                r_unread;
`ifdef PS2_OVERRUN_EN
   logic                r_overrun;
`endif

   logic r_kclk_s1, r_kclk_s2, r_kclk_d;
   logic r_kdata_s1, r_kdata_s2;

   logic        w_fall;
   logic        w_rd;
   logic        w_wr;
   logic [21:0] w_word;
   logic        w_rd_code;
   logic        w_soft;
   logic        w_timeout;
   logic        w_accept;
   logic        w_unused_ok;

   assign ready_o = 1'b1;

   // Synchronisers idle high so reset never fabricates a falling edge
   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         r_kclk_s1  <= 1'b1;
         r_kclk_s2  <= 1'b1;
         r_kclk_d   <= 1'b1;
         r_kdata_s1 <= 1'b1;
         r_kdata_s2 <= 1'b1;
      end else begin
         r_kclk_s1  <= kclk_i;
         r_kclk_s2  <= r_kclk_s1;
         r_kclk_d   <= r_kclk_s2;
         r_kdata_s1 <= kdata_i;
         r_kdata_s2 <= r_kdata_s1;
      end
   end

   assign w_fall    = r_kclk_d & ~r_kclk_s2;
   assign w_rd      = req_i & ~write_enable_i;
   assign w_wr      = req_i & write_enable_i;
   assign w_word    = addr_i[23:2];
   assign w_rd_code = w_rd && (w_word == 22'd0);
   assign w_soft    = w_wr && (w_word == 22'd9) && write_data_i[0];
   assign w_timeout = (r_state != ST_IDLE) && (r_to_cnt >= c_to_w'(TIMEOUT_CYCLES));
   assign w_accept  = w_fall && !w_timeout && (r_state == ST_STOP) && r_kdata_s2
                      && (^{r_shift, r_parity});

   assign w_unused_ok = &{1'b0, addr_i[31:24], addr_i[1:0], write_data_i[31:1]};

   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         r_state             <= ST_IDLE;
         r_bit_cnt           <= 3'd0;
         r_shift             <= 8'd0;
         r_parity            <= 1'b0;
         r_to_cnt            <= '0;
         r_scan_code         <= 8'd0;
         r_unread            <= 1'b0;
         interrupt_request_o <= 1'b0;
`ifdef PS2_OVERRUN_EN
         r_overrun           <= 1'b0;
`endif
      end else if (w_soft) begin
         r_state             <= ST_IDLE;
         r_bit_cnt           <= 3'd0;
         r_shift             <= 8'd0;
         r_parity            <= 1'b0;
         r_to_cnt            <= '0;
         r_scan_code         <= 8'd0;
         r_unread            <= 1'b0;
         interrupt_request_o <= 1'b0;
`ifdef PS2_OVERRUN_EN
         r_overrun           <= 1'b0;
`endif
      end else begin
         if (w_fall || r_state == ST_IDLE)
            r_to_cnt <= '0;
         else
            r_to_cnt <= r_to_cnt + 1'b1;

         if (w_timeout) begin
            r_state <= ST_IDLE;
         end else if (w_fall) begin
            case (r_state)
               ST_IDLE: begin
                  if (!r_kdata_s2) begin
                     r_state   <= ST_DATA;
                     r_bit_cnt <= 3'd0;
                  end
               end
               ST_DATA: begin
                  r_shift   <= {r_kdata_s2, r_shift[7:1]};
                  r_bit_cnt <= r_bit_cnt + 3'd1;
                  if (r_bit_cnt == 3'd7)
                     r_state <= ST_PARITY;
               end
               ST_PARITY: begin
                  r_parity <= r_kdata_s2;
                  r_state  <= ST_STOP;
               end
               default: r_state <= ST_IDLE;
            endcase
         end

         // A new code always beats a same-cycle read or IRQ acknowledge
         if (w_accept) begin
            r_scan_code         <= r_shift;
            r_unread            <= 1'b1;
            interrupt_request_o <= 1'b1;
         end else begin
            if (w_rd_code) begin
               r_unread            <= 1'b0;
               interrupt_request_o <= 1'b0;
            end
            if (interrupt_return_i)
               interrupt_request_o <= 1'b0;
         end

`ifdef PS2_OVERRUN_EN
         if (w_accept && r_unread)
            r_overrun <= 1'b1;
         else if (w_wr && (w_word == 22'd2))
            r_overrun <= 1'b0;
`endif
      end
   end

   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         read_data_o <= 32'd0;
      end else if (w_rd) begin
         case (w_word)
            22'd0:   read_data_o <= {24'd0, r_scan_code};
            22'd1:   read_data_o <= {31'd0, r_unread};
`ifdef PS2_OVERRUN_EN
            22'd2:   read_data_o <= {31'd0, r_overrun};
`endif
            default: read_data_o <= 32'd0;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_ps2_sb_ctrl.sv
// ============================================================================
// Module  : tb_ps2_sb_ctrl
// Brief   : Self-checking bench for ps2_sb_ctrl (table, corner cases, random).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ps2_sb_ctrl;

   logic        clk;
   logic        resetn;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ready;
   logic        kclk;
   logic        kdata;
   logic        irq;
   logic        iret;

   int total = 0;
   int bad   = 0;

   // Reference model state: what software should observe
   logic [7:0] mdl_code;
   logic       mdl_unread;
   logic       mdl_irq;
   logic       mdl_ovr;

   ps2_sb_ctrl #(.TIMEOUT_CYCLES(2000)) dut (
      .clk_i               (clk),
      .resetn_i            (resetn),
      .req_i               (req),
      .write_enable_i      (we),
      .addr_i              (addr),
      .write_data_i        (wdata),
      .read_data_o         (rdata),
      .ready_o             (ready),
      .kclk_i              (kclk),
      .kdata_i             (kdata),
      .interrupt_request_o (irq),
      .interrupt_return_i  (iret)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: act=running req=finished");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: act=0x%08h req=0x%08h", name, act, exp);
      end
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
      req = 1'b1; we = 1'b0; addr = a;
      @(negedge clk);
      d = rdata;
      req = 1'b0;
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      req = 1'b1; we = 1'b1; addr = a; wdata = d;
      @(negedge clk);
      req = 1'b0; we = 1'b0;
   endtask

   // Sends the first nbits bits of a frame; optionally issues a 0x00 read
   // sampled on exactly the same clock edge that accepts the stop bit.
   task automatic send_frame(input logic [7:0] code, input bit bad_par, input int nbits,
                             input bit align_read, output logic [31:0] rd);
      logic [10:0] bits;
      bits = {1'b1, (~^code) ^ bad_par, code, 1'b0};
      rd = 32'hDEAD_BEEF;
      for (int i = 0; i < nbits; i++) begin
         kdata = bits[i];
         repeat (50) @(negedge clk);
         kclk = 1'b0;
         if (align_read && i == 10) begin
            repeat (2) @(negedge clk);
            bus_read(32'h0, rd);
            repeat (47) @(negedge clk);
         end else begin
            repeat (50) @(negedge clk);
         end
         kclk = 1'b1;
      end
      kdata = 1'b1;
      repeat (10) @(negedge clk);
   endtask

   function automatic void mdl_frame(input logic [7:0] code, input bit bad_par);
      if (!bad_par) begin
         if (mdl_unread) mdl_ovr = 1'b1;
         mdl_code   = code;
         mdl_unread = 1'b1;
         mdl_irq    = 1'b1;
      end
   endfunction

   function automatic logic [31:0] exp_ovr(input logic v);
`ifdef PS2_OVERRUN_EN
      return {31'd0, v};
`else
      return 32'd0 & {31'd0, v};
`endif
   endfunction

   typedef struct {
      logic [7:0]  code;
      bit          bad_par;
      logic [31:0] exp_unread;
      logic        exp_irq;
      logic [31:0] exp_code;
   } vec_t;

   vec_t vecs[6];

   initial begin
      logic [31:0] d;
      logic [7:0]  rc;
      bit          rb;

      vecs[0] = '{8'h1C, 1'b0, 32'd1, 1'b1, 32'h1C};
      vecs[1] = '{8'h1C, 1'b1, 32'd0, 1'b0, 32'h1C};
      vecs[2] = '{8'hF0, 1'b0, 32'd1, 1'b1, 32'hF0};
      vecs[3] = '{8'h00, 1'b0, 32'd1, 1'b1, 32'h00};
      vecs[4] = '{8'hFF, 1'b0, 32'd1, 1'b1, 32'hFF};
      vecs[5] = '{8'hA5, 1'b1, 32'd0, 1'b0, 32'hFF};

      resetn = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
      kclk = 1'b1; kdata = 1'b1; iret = 1'b0;
      repeat (4) @(negedge clk);
      check("reset_rdata", rdata, 32'd0);
      check("reset_irq", {31'd0, irq}, 32'd0);
      check("ready", {31'd0, ready}, 32'd1);
      resetn = 1'b1;
      repeat (3) @(negedge clk);
      bus_read(32'h4, d); check("reset_unread", d, 32'd0);
      bus_read(32'h0, d); check("reset_code", d, 32'd0);

      // Table-driven frames
      for (int i = 0; i < 6; i++) begin
         send_frame(vecs[i].code, vecs[i].bad_par, 11, 1'b0, d);
         bus_read(32'h4, d); check($sformatf("tbl%0d_unread", i), d, vecs[i].exp_unread);
         check($sformatf("tbl%0d_irq", i), {31'd0, irq}, {31'd0, vecs[i].exp_irq});
         bus_read(32'h0, d); check($sformatf("tbl%0d_code", i), d, vecs[i].exp_code);
         bus_read(32'h4, d); check($sformatf("tbl%0d_unread_clr", i), d, 32'd0);
         check($sformatf("tbl%0d_irq_clr", i), {31'd0, irq}, 32'd0);
      end

      // Abandoned frame then timeout; next frame must align
      send_frame(8'h33, 1'b0, 5, 1'b0, d);
      repeat (2100) @(negedge clk);
      send_frame(8'h5A, 1'b0, 11, 1'b0, d);
      bus_read(32'h0, d); check("timeout_code", d, 32'h5A);

      // IRQ acknowledge keeps unread; overrun on second unread code
      send_frame(8'h1C, 1'b0, 11, 1'b0, d);
      iret = 1'b1; @(negedge clk); iret = 1'b0;
      check("iret_irq", {31'd0, irq}, 32'd0);
      bus_read(32'h4, d); check("iret_unread", d, 32'd1);
      send_frame(8'h32, 1'b0, 11, 1'b0, d);
      bus_read(32'h0, d); check("ovr_code", d, 32'h32);
      bus_read(32'h8, d); check("ovr_set", d, exp_ovr(1'b1));
      bus_write(32'h8, 32'h0);
      bus_read(32'h8, d); check("ovr_clr", d, 32'd0);

      // Hardware reset mid-frame
      send_frame(8'h1C, 1'b0, 11, 1'b0, d);
      bus_read(32'h0, d); check("pre_rst_code", d, 32'h1C);
      send_frame(8'h77, 1'b0, 5, 1'b0, d);
      resetn = 1'b0;
      repeat (3) @(negedge clk);
      check("midrst_rdata", rdata, 32'd0);
      check("midrst_irq", {31'd0, irq}, 32'd0);
      resetn = 1'b1;
      repeat (200) @(negedge clk);
      bus_read(32'h4, d); check("midrst_unread", d, 32'd0);
      check("midrst_irq_after", {31'd0, irq}, 32'd0);

      // Soft reset after an accepted code
      send_frame(8'h1C, 1'b0, 11, 1'b0, d);
      bus_read(32'h4, d); check("soft_pre_unread", d, 32'd1);
      bus_write(32'h24, 32'h1);
      bus_read(32'h4, d); check("soft_unread", d, 32'd0);
      check("soft_irq", {31'd0, irq}, 32'd0);
      bus_read(32'h0, d); check("soft_code", d, 32'd0);

      // Read of old code on the accepting edge of a new code
      send_frame(8'h11, 1'b0, 11, 1'b0, d);
      send_frame(8'h22, 1'b0, 11, 1'b1, d);
      check("align_old_code", d, 32'h11);
      bus_read(32'h4, d); check("align_unread", d, 32'd1);
      check("align_irq", {31'd0, irq}, 32'd1);
      bus_read(32'h8, d); check("align_ovr", d, exp_ovr(1'b1));
      bus_read(32'h0, d); check("align_new_code", d, 32'h22);

      // Random frames against the reference model
      bus_write(32'h24, 32'h1);
      mdl_code = 8'h00; mdl_unread = 1'b0; mdl_irq = 1'b0; mdl_ovr = 1'b0;
      for (int n = 0; n < 14; n++) begin
         rc = 8'($urandom);
         rb = ($urandom_range(0, 3) == 0);
         send_frame(rc, rb, 11, 1'b0, d);
         mdl_frame(rc, rb);
         if ($urandom_range(0, 3) == 0) begin
            iret = 1'b1; @(negedge clk); iret = 1'b0;
            mdl_irq = 1'b0;
         end
         check($sformatf("rnd%0d_irq", n), {31'd0, irq}, {31'd0, mdl_irq});
         bus_read(32'h4, d); check($sformatf("rnd%0d_unread", n), d, {31'd0, mdl_unread});
         bus_read(32'h8, d); check($sformatf("rnd%0d_ovr", n), d, exp_ovr(mdl_ovr));
         if ($urandom_range(0, 1) == 1) begin
            bus_read(32'h0, d); check($sformatf("rnd%0d_code", n), d, {24'd0, mdl_code});
            mdl_unread = 1'b0; mdl_irq = 1'b0;
         end
         bus_read(32'h10, d); check($sformatf("rnd%0d_unmapped", n), d, 32'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
